// File: rtl/biquad8_pkg.sv
// Shared types and constants for the biquad coefficient loader.
package biquad8_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_XFER,
        ST_UPD,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam logic [6:0] OFF_UPD  = 7'h00;
    localparam logic [6:0] OFF_ZERO = 7'h04;
    localparam logic [6:0] OFF_POLE = 7'h10;

    localparam int unsigned MEM_AW = 16;
    localparam int unsigned MEM_DW = 18;
    localparam int unsigned WB_DW  = 32;

endpackage

// File: rtl/biquad8_coeff_addr_map.sv
// Maps a per-channel coefficient index to its register offset inside the filter block.
module biquad8_coeff_addr_map
    import biquad8_pkg::*;
#(
    parameter int unsigned NZERO = 4,
    parameter int unsigned NPOLE = 2
) (
    input  logic [MEM_AW-1:0] k,
    output logic [6:0]        offset_c
);

    logic [MEM_AW-1:0] slot;

    // Zero taps all share one offset; pole taps fill four slots NPOLE words at a time.
    always_comb begin
        slot     = '0;
        offset_c = OFF_ZERO;
        if (k >= MEM_AW'(NZERO)) begin
            slot     = (k - MEM_AW'(NZERO)) / MEM_AW'(NPOLE);
            offset_c = OFF_POLE + 7'(slot << 2);
        end
    end

endmodule

// File: rtl/biquad8_coeff_loader.sv
// Streams one channel's coefficients from RAM into the filter over Wishbone,
// optionally followed by an update write; aborts on bus error or ack timeout.
module biquad8_coeff_loader
    import biquad8_pkg::*;
#(
    parameter int unsigned NZERO   = 4,
    parameter int unsigned NPOLE   = 2,
    parameter int unsigned NCHBITS = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rstn_i,
    input  logic                 start_i,
    input  logic [NCHBITS-1:0]   ch_i,
    input  logic                 apply_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [MEM_AW-1:0]    mem_adr_o,
    output logic                 mem_rd_o,
    input  logic [MEM_DW-1:0]    mem_dat_i,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    output logic                 wb_we_o,
    output logic [NCHBITS+6:0]   wb_adr_o,
    output logic [WB_DW-1:0]     wb_dat_o,
    output logic [3:0]           wb_sel_o,
    input  logic                 wb_ack_i,
    input  logic                 wb_err_i
);

    localparam int unsigned W  = NZERO + 4 * NPOLE;
    localparam int unsigned AW = NCHBITS + 7;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [MEM_AW-1:0] W_K = MEM_AW'(W);

    if (NCHBITS >= MEM_AW || W > (32'd1 << (MEM_AW - NCHBITS))) begin : g_bad_w
        $error("coefficient words per channel exceed the per-channel RAM window");
    end
    if (NPOLE == 0 || TIMEOUT == 0) begin : g_bad_param
        $error("NPOLE and TIMEOUT must be non-zero");
    end

    state_e              state_q, state_d;
    logic [MEM_AW-1:0]   k_q, k_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NCHBITS-1:0]  ch_q, ch_d;
    logic                apply_q, apply_d;
    logic                busy_d, done_d, err_d, mem_rd_d, cyc_d, we_d;
    logic [MEM_AW-1:0]   mem_adr_d;
    logic [AW-1:0]       adr_d;
    logic [WB_DW-1:0]    dat_d;
    logic [3:0]          sel_d;
    logic [6:0]          offset_c;

    biquad8_coeff_addr_map #(
        .NZERO (NZERO),
        .NPOLE (NPOLE)
    ) u_addr_map (
        .k        (k_q),
        .offset_c (offset_c)
    );

    assign wb_stb_o = wb_cyc_o;

    // State and registered outputs.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            cnt_q     <= '0;
            ch_q      <= '0;
            apply_q   <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            mem_rd_o  <= 1'b0;
            mem_adr_o <= '0;
            wb_cyc_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            wb_sel_o  <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            apply_q   <= apply_d;
            busy_o    <= busy_d;
            done_o    <= done_d;
            err_o     <= err_d;
            mem_rd_o  <= mem_rd_d;
            mem_adr_o <= mem_adr_d;
            wb_cyc_o  <= cyc_d;
            wb_we_o   <= we_d;
            wb_adr_o  <= adr_d;
            wb_dat_o  <= dat_d;
            wb_sel_o  <= sel_d;
        end
    end

    // Next state and next values of the registered outputs.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        ch_d      = ch_q;
        apply_d   = apply_q;
        busy_d    = busy_o;
        done_d    = 1'b0;
        err_d     = 1'b0;
        mem_rd_d  = 1'b0;
        mem_adr_d = mem_adr_o;
        cyc_d     = wb_cyc_o;
        we_d      = wb_we_o;
        adr_d     = wb_adr_o;
        dat_d     = wb_dat_o;
        sel_d     = wb_sel_o;

        case (state_q)
            ST_IDLE: begin
                if (start_i && !busy_o) begin
                    state_d   = ST_FETCH;
                    ch_d      = ch_i;
                    apply_d   = apply_i;
                    k_d       = '0;
                    busy_d    = 1'b1;
                    mem_rd_d  = 1'b1;
                    mem_adr_d = MEM_AW'(ch_i) * W_K;
                end
            end
            ST_FETCH: state_d = ST_LATCH;
            ST_LATCH: begin
                state_d = ST_XFER;
                cnt_d   = '0;
                cyc_d   = 1'b1;
                we_d    = 1'b1;
                sel_d   = 4'hF;
                adr_d   = {ch_q, offset_c};
                dat_d   = WB_DW'(mem_dat_i);
            end
            ST_XFER, ST_UPD: begin
                // The update write is presented one cycle after entering UPD so cyc drops between writes.
                if (!wb_cyc_o) begin
                    cnt_d = '0;
                    cyc_d = 1'b1;
                    we_d  = 1'b1;
                    sel_d = 4'hF;
                    adr_d = {ch_q, OFF_UPD};
                    dat_d = WB_DW'(1);
                end else if (wb_err_i || (!wb_ack_i && cnt_q == CW'(TIMEOUT - 1))) begin
                    state_d = ST_ERR;
                    cnt_d   = '0;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = '0;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end else if (wb_ack_i) begin
                    cnt_d = '0;
                    cyc_d = 1'b0;
                    we_d  = 1'b0;
                    sel_d = '0;
                    if (state_q == ST_XFER) begin
                        k_d = k_q + 16'd1;
                    end
                    if (state_q == ST_XFER && (k_q + 16'd1) < W_K) begin
                        state_d   = ST_FETCH;
                        mem_rd_d  = 1'b1;
                        mem_adr_d = MEM_AW'(ch_q) * W_K + k_q + 16'd1;
                    end else if (state_q == ST_XFER && apply_q) begin
                        state_d = ST_UPD;
                    end else begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// Directed bench for the biquad coefficient loader with a RAM model and a scripted Wishbone target.
module tb_biquad8_coeff_loader;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        start_i = 1'b0;
    logic [3:0]  ch_i = 4'd0;
    logic        apply_i = 1'b0;
    logic        busy_o, done_o, err_o;
    logic [15:0] mem_adr_o;
    logic        mem_rd_o;
    logic [17:0] mem_dat_i = 18'd0;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [10:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i, wb_err_i;

    int checks = 0;
    int errors = 0;

    // Target script: transfer number (1-based) that gets err / never gets ack; 0 = none.
    int hold_at = 0;
    int err_at  = 0;
    logic clr = 1'b0;

    int n_xfer, n_wr, n_done, n_err, run, last_run;
    logic [10:0] wr_adr [32];
    logic [31:0] wr_dat [32];
    logic [3:0]  wr_sel [32];

    int offs [12] = '{4, 4, 4, 4, 16, 16, 20, 20, 24, 24, 28, 28};
    int wait_n;

    biquad8_coeff_loader #(
        .NZERO   (4),
        .NPOLE   (2),
        .NCHBITS (4),
        .TIMEOUT (8)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rstn_i (rstn),
        .start_i   (start_i),
        .ch_i      (ch_i),
        .apply_i   (apply_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .mem_adr_o (mem_adr_o),
        .mem_rd_o  (mem_rd_o),
        .mem_dat_i (mem_dat_i),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_sel_o  (wb_sel_o),
        .wb_ack_i  (wb_ack_i),
        .wb_err_i  (wb_err_i)
    );

    always #5 clk = ~clk;

    // RAM: word at address a holds {2'b10, a}, valid one cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd_o) mem_dat_i <= {2'b10, mem_adr_o};
    end

    // Target: acks one cycle after seeing a strobe, unless scripted otherwise.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wb_ack_i <= 1'b0;
            wb_err_i <= 1'b0;
        end else begin
            wb_ack_i <= 1'b0;
            wb_err_i <= 1'b0;
            if (wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i) begin
                if (n_xfer + 1 == err_at) wb_err_i <= 1'b1;
                else if (n_xfer + 1 != hold_at) wb_ack_i <= 1'b1;
            end
        end
    end

    // Monitor: logs completed writes, pulses and strobe run lengths.
    always @(posedge clk) begin
        if (clr) begin
            n_xfer <= 0; n_wr <= 0; n_done <= 0; n_err <= 0; run <= 0; last_run <= 0;
        end else begin
            if (wb_cyc_o && wb_stb_o && (wb_ack_i || wb_err_i)) n_xfer <= n_xfer + 1;
            if (wb_cyc_o && wb_stb_o && wb_ack_i && !wb_err_i && n_wr < 32) begin
                wr_adr[n_wr] <= wb_adr_o;
                wr_dat[n_wr] <= wb_dat_o;
                wr_sel[n_wr] <= wb_sel_o;
                n_wr <= n_wr + 1;
            end
            if (done_o) n_done <= n_done + 1;
            if (err_o) n_err <= n_err + 1;
            if (wb_cyc_o) run <= run + 1;
            else begin
                if (run != 0) last_run <= run;
                run <= 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic clear_log();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    initial begin
        // Reset
        #2 rstn = 1'b0;
        #3;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_pulses", 32'({done_o, err_o, mem_rd_o}), 32'd0);
        check("rst_wb", 32'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}), 32'd0);
        check("rst_adr", 32'({wb_adr_o, mem_adr_o}), 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        cycles(3);
        rstn = 1'b1;
        clear_log();

        // A: ch 3, apply, every write acked
        @(negedge clk); start_i = 1'b1; ch_i = 4'd3; apply_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        check("A_busy", 32'(busy_o), 32'd1);
        check("A_mem_rd", 32'(mem_rd_o), 32'd1);
        check("A_mem_adr", 32'(mem_adr_o), 32'd36);
        wait_n = 0;
        while (!done_o && wait_n < 600) begin @(negedge clk); wait_n++; end
        check("A_done", 32'(done_o), 32'd1);
        check("A_busy_low", 32'(busy_o), 32'd0);
        @(negedge clk);
        check("A_done_pulse", 32'(done_o), 32'd0);
        check("A_n_wr", 32'(n_wr), 32'd13);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("A_adr%0d", i), 32'(wr_adr[i]), 32'(3 * 128 + offs[i]));
            check($sformatf("A_dat%0d", i), wr_dat[i], 32'h20000 + 32'(36 + i));
        end
        check("A_sel0", 32'(wr_sel[0]), 32'hF);
        check("A_upd_adr", 32'(wr_adr[12]), 32'h180);
        check("A_upd_dat", wr_dat[12], 32'h1);
        check("A_upd_sel", 32'(wr_sel[12]), 32'hF);
        check("A_n_done", 32'(n_done), 32'd1);
        clear_log();

        // B: ch 1, no apply, start retriggered while busy
        @(negedge clk); start_i = 1'b1; ch_i = 4'd1; apply_i = 1'b0;
        @(negedge clk); start_i = 1'b0;
        cycles(8);
        start_i = 1'b1; ch_i = 4'd2; apply_i = 1'b1;
        cycles(3);
        start_i = 1'b0;
        wait_n = 0;
        while (!done_o && wait_n < 600) begin @(negedge clk); wait_n++; end
        check("B_done", 32'(done_o), 32'd1);
        cycles(30);
        check("B_n_wr", 32'(n_wr), 32'd12);
        check("B_n_xfer", 32'(n_xfer), 32'd12);
        check("B_last_adr", 32'(wr_adr[11]), 32'h09C);
        check("B_first_dat", wr_dat[0], 32'h2000C);
        check("B_n_done", 32'(n_done), 32'd1);
        check("B_idle", 32'({busy_o, wb_cyc_o}), 32'd0);
        clear_log();

        // C: 5th write never acked, TIMEOUT 8
        hold_at = 5;
        @(negedge clk); start_i = 1'b1; ch_i = 4'd0; apply_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        wait_n = 0;
        while (!err_o && wait_n < 600) begin @(negedge clk); wait_n++; end
        check("C_err", 32'(err_o), 32'd1);
        check("C_cyc_low", 32'(wb_cyc_o), 32'd0);
        check("C_busy_low", 32'(busy_o), 32'd0);
        @(negedge clk);
        check("C_err_pulse", 32'(err_o), 32'd0);
        cycles(30);
        check("C_run", 32'(last_run), 32'd8);
        check("C_n_wr", 32'(n_wr), 32'd4);
        check("C_counts", 32'({n_err[7:0], n_done[7:0]}), 32'h0100);
        hold_at = 0;
        clear_log();

        // D: bus error on the 2nd write
        err_at = 2;
        @(negedge clk); start_i = 1'b1; ch_i = 4'd2; apply_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        wait_n = 0;
        while (!wb_err_i && wait_n < 600) begin @(negedge clk); wait_n++; end
        check("D_err_in", 32'(wb_err_i), 32'd1);
        check("D_busy_before", 32'(busy_o), 32'd1);
        @(negedge clk);
        check("D_err", 32'(err_o), 32'd1);
        check("D_busy_low", 32'(busy_o), 32'd0);
        check("D_cyc_low", 32'(wb_cyc_o), 32'd0);
        cycles(30);
        check("D_n_wr", 32'(n_wr), 32'd1);
        check("D_n_xfer", 32'(n_xfer), 32'd2);
        check("D_counts", 32'({n_err[7:0], n_done[7:0]}), 32'h0100);
        err_at = 0;
        clear_log();

        // E: reset during a transfer
        @(negedge clk); start_i = 1'b1; ch_i = 4'd4; apply_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        wait_n = 0;
        while (!wb_cyc_o && wait_n < 100) begin @(negedge clk); wait_n++; end
        check("E_in_xfer", 32'(wb_cyc_o), 32'd1);
        rstn = 1'b0;
        #1;
        check("E_wb", 32'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}), 32'd0);
        check("E_status", 32'({busy_o, done_o, err_o, mem_rd_o}), 32'd0);
        check("E_adr", 32'({wb_adr_o, mem_adr_o}), 32'd0);
        check("E_dat", wb_dat_o, 32'd0);
        cycles(3);
        rstn = 1'b1;
        cycles(20);
        check("E_idle", 32'({busy_o, wb_cyc_o, mem_rd_o}), 32'd0);
        check("E_counts", 32'({n_err[7:0], n_done[7:0]}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/biquad8_coeff_loader.md
BIQUAD8_COEFF_LOADER -- requirements
Module: biquad8_coeff_loader

Interface
REQ-001 SHALL have parameter NZERO, default 4: zero-FIR coefficient writes per channel, all to offset 0x04.
REQ-002 SHALL have parameter NPOLE, default 2: writes per pole-FIR slot; slots are offsets 0x10, 0x14, 0x18, 0x1C, in that order.
REQ-003 SHALL have parameter NCHBITS, default 4: channel select width; channel c occupies master address {c, 7-bit offset}.
REQ-004 SHALL have parameter TIMEOUT, default 255: maximum wait in cycles for ack per transfer.
REQ-005 SHALL have ports: wb_clk_i in 1, the only clock; wb_rstn_i in 1, reset, asynchronous active-low.
REQ-006 SHALL have ports: start_i in 1, start a load; ch_i in NCHBITS, target channel; apply_i in 1, issue update write after coefficients.
REQ-007 SHALL have ports: busy_o out 1; done_o out 1, one-cycle pulse on success; err_o out 1, one-cycle pulse on abort.
REQ-008 SHALL have ports: mem_adr_o out 16, coefficient RAM address; mem_rd_o out 1, read strobe; mem_dat_i in 18, read data valid exactly 1 cycle after mem_rd_o.
REQ-009 SHALL have ports: wb_cyc_o, wb_stb_o, wb_we_o out 1; wb_adr_o out NCHBITS+7; wb_dat_o out 32; wb_sel_o out 4; wb_ack_i, wb_err_i in 1.

Function
REQ-010 SHALL define W = NZERO + 4*NPOLE words per channel; the RAM word for channel c, index k, is at c*W + k.
REQ-011 SHALL map index k to an offset: k < NZERO gives 0x04; otherwise (k-NZERO)/NPOLE selects slot 0x10 + 4*slot.
REQ-012 SHALL run an FSM with states IDLE -> FETCH -> LATCH -> XFER -> (FETCH | UPD | DONE) plus ERR.
REQ-013 SHALL, in IDLE, accept start_i only while not busy; on accept, capture ch_i and apply_i, set k=0, assert busy_o next cycle.
REQ-014 SHALL, in FETCH, assert mem_rd_o for one cycle with mem_adr_o = ch*W + k.
REQ-015 SHALL, in LATCH, register mem_dat_i zero-extended to 32 bits into wb_dat_o.
REQ-016 SHALL, in XFER, hold cyc/stb/we high, sel = 4'hF, and adr/dat stable until wb_ack_i; it SHALL deassert cyc/stb in the cycle after the ack.
REQ-017 SHALL, after an acked XFER, increment k; if k < W, go to FETCH; else go to UPD when apply was captured, otherwise to DONE.
REQ-018 SHALL, in UPD, issue one transfer to offset 0x00 with dat 32'h1 and sel 4'hF, then go to DONE.
REQ-019 SHALL, in DONE, pulse done_o for one cycle and return to IDLE with busy_o low.
REQ-020 SHALL count cycles in XFER/UPD; if the count reaches TIMEOUT without ack, or wb_err_i is high, it SHALL drop cyc/stb and go to ERR.
REQ-021 SHALL, in ERR, pulse err_o for one cycle, then return to IDLE; no update write is issued after an abort.
REQ-022 SHALL treat ack and err arriving in the same cycle as err.
REQ-023 SHALL ignore start_i while busy, with no queuing.
REQ-024 SHALL allow total loads per channel (W) up to 2^16/2^NCHBITS; this SHALL be enforced by an elaboration-time check.

Reset
REQ-025 SHALL, while wb_rstn_i is low, asynchronously force: FSM to IDLE; k and the timeout counter to 0; every output to 0.
REQ-026 SHALL, on reset mid-transfer, drop cyc/stb immediately and produce no done_o or err_o pulse.

Structure
REQ-027 SHALL place the state enum and offset constants (0x00, 0x04, 0x10) in shared package biquad8_pkg.
REQ-028 SHALL contain one sub-module, biquad8_coeff_addr_map, which is combinational (k -> offset) and implements REQ-011.

Verification
REQ-029 SHALL cover: NZERO=4, NPOLE=2, ch=3, apply=1, target acks in 1 cycle -> 12 writes at 0x184 x4, 0x190 x2, 0x194 x2, 0x198 x2, 0x19C x2, then 0x180 dat 1, then done_o.
REQ-030 SHALL cover: apply=0 -> exactly 12 writes, no 0x00 write, done_o pulse.
REQ-031 SHALL cover: target withholds ack on the 5th write, TIMEOUT=8 -> cyc low after 8 cycles, err_o pulse, no further writes.
REQ-032 SHALL cover: wb_err_i on the 2nd write -> abort, err_o pulse, busy_o low on the next cycle.
REQ-033 SHALL cover: start_i reasserted while busy -> ignored, exactly one load sequence.
REQ-034 SHALL cover: reset asserted during XFER -> all outputs 0 immediately, FSM in IDLE, no done_o or err_o.
